// File: rtl/intc_core.sv
// intc_core: memory-mapped interrupt controller with synchronized event and acknowledge inputs.
// Define INTC_ROUND_ROBIN_EN for rotating priority; the default build uses fixed lowest-index priority.
module intc_core #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    done,
  input  logic                  IACK,
  input  logic [DATA_WIDTH-1:0] input_addr,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  IRQ,
  output logic [DATA_WIDTH-1:0] isr_addr
);

  // state    | meaning
  // IDLE     | no grant outstanding, waiting for an enabled pending source
  // SERVE    | IRQ high, isr_addr holds the granted vector, waiting for IACK rise
  // ACKWAIT  | acknowledged, waiting for IACK to drop
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE   = 2'd1;
  localparam logic [1:0] ST_ACKWAIT = 2'd2;

  localparam int AW = DATA_WIDTH - 2;

  logic [NUM_SRC-1:0]    r_done_s1, r_done_s2, r_done_d;
  logic                  r_iack_s1, r_iack_s2, r_iack_d;
  logic [NUM_SRC-1:0]    r_en, r_pend;
  logic [DATA_WIDTH-1:0] r_vec [NUM_SRC];
  logic [1:0]            r_state;
  logic [2:0]            r_gnt;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_isr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [NUM_SRC-1:0]    w_done_rise;
  logic                  w_iack_rise;
  logic [AW-1:0]         w_word;
  logic [1:0]            w_unused_addr_lo;
  logic [NUM_SRC-1:0]    w_req;
  logic                  w_any;
  logic [2:0]            w_win;
  logic [DATA_WIDTH-1:0] w_win_vec;
  logic [NUM_SRC-1:0]    w_w1c_mask;
  logic [NUM_SRC-1:0]    w_ack_mask;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_done_rise      = r_done_s2 & ~r_done_d;
  assign w_iack_rise      = r_iack_s2 & ~r_iack_d;
  assign w_word           = input_addr[DATA_WIDTH-1:2];
  assign w_unused_addr_lo = input_addr[1:0];
  assign w_req            = r_pend & r_en;
  assign w_any            = |w_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_s1 <= '0;
      r_done_s2 <= '0;
      r_done_d  <= '0;
      r_iack_s1 <= 1'b0;
      r_iack_s2 <= 1'b0;
      r_iack_d  <= 1'b0;
    end else begin
      r_done_s1 <= done;
      r_done_s2 <= r_done_s1;
      r_done_d  <= r_done_s2;
      r_iack_s1 <= IACK;
      r_iack_s2 <= r_iack_s1;
      r_iack_d  <= r_iack_s2;
    end
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [2:0]         r_rr_start;
  logic [NUM_SRC-1:0] w_req_rot;
  logic [3:0]         w_rr_sum;

  // Rotate requests so the search always begins at bit 0, then map back.
  always_comb begin
    w_req_rot = NUM_SRC'({w_req, w_req} >> r_rr_start);
    w_rr_sum  = '0;
    w_win     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_rr_sum = {1'b0, r_rr_start} + 4'(k);
        if (w_rr_sum >= 4'(NUM_SRC)) w_rr_sum = w_rr_sum - 4'(NUM_SRC);
        w_win = w_rr_sum[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_start <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_rr_start <= (w_win == 3'(NUM_SRC - 1)) ? 3'd0 : w_win + 3'd1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_req[k]) w_win = 3'(k);
    end
  end
`endif

  always_comb begin
    w_win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win == 3'(i)) w_win_vec = r_vec[i];
    end
  end

  assign w_w1c_mask = (write_enable && w_word == AW'(1)) ? write_data[NUM_SRC-1:0] : '0;
  assign w_ack_mask = (r_state == ST_SERVE && w_iack_rise) ? (NUM_SRC'(1) << r_gnt) : '0;

  // A new event outranks a clear landing on the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en   <= '0;
      r_pend <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_vec[i] <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_w1c_mask | w_ack_mask)) | w_done_rise;
      if (write_enable && w_word == '0) r_en <= write_data[NUM_SRC-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (write_enable && w_word == AW'(4 + i)) r_vec[i] <= write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_irq   <= 1'b0;
      r_isr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_isr   <= w_win_vec;
            r_irq   <= 1'b1;
            r_state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (w_iack_rise) begin
            r_irq   <= 1'b0;
            r_state <= ST_ACKWAIT;
          end
        end
        ST_ACKWAIT: begin
          if (!r_iack_s2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_word == '0) begin
      w_rdata[NUM_SRC-1:0] = r_en;
    end else if (w_word == AW'(1)) begin
      w_rdata[NUM_SRC-1:0] = r_pend;
    end else if (w_word == AW'(2)) begin
      w_rdata[DATA_WIDTH-1] = (r_state != ST_IDLE);
      w_rdata[2:0]          = r_gnt;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_word == AW'(4 + i)) w_rdata = r_vec[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= '0;
    else      r_rdata <= w_rdata;
  end

  assign read_data = r_rdata;
  assign IRQ       = r_irq;
  assign isr_addr  = r_isr;

endmodule

// File: tb/tb_intc_core.sv
// Self-checking bench for intc_core: directed scenarios plus random traffic against a cycle model.
module tb_intc_core;
  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  done = '0;
  logic          IACK = 1'b0;
  logic [DW-1:0] input_addr = '0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          IRQ;
  logic [DW-1:0] isr_addr;

  intc_core #(.DATA_WIDTH(DW), .NUM_SRC(N)) dut (
    .clk(clk), .rst(rst), .done(done), .IACK(IACK),
    .input_addr(input_addr), .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data), .IRQ(IRQ), .isr_addr(isr_addr)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: registers as plain variables, input synchronizers as sample histories.
  logic [N-1:0]  m_en, m_pend, m_h1, m_h2, m_h3;
  logic [DW-1:0] m_vec [N];
  logic          m_a1, m_a2, m_a3;
  bit            m_busy, m_release;
  int            m_gid, m_rr;
  logic          m_irq;
  logic [DW-1:0] m_isr, m_rdata;

  function automatic logic [DW-1:0] m_read(input logic [DW-1:0] a);
    int word = int'(a >> 2);
    logic [DW-1:0] r = '0;
    if (word == 0) r = DW'(m_en);
    else if (word == 1) r = DW'(m_pend);
    else if (word == 2) r = {(m_busy || m_release), 28'd0, 3'(m_gid)};
    else if (word >= 4 && word < 4 + N) r = m_vec[word - 4];
    return r;
  endfunction

  function automatic int m_pick(input logic [N-1:0] req);
    int start = 0;
`ifdef INTC_ROUND_ROBIN_EN
    start = m_rr;
`endif
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic m_reset();
    m_en = '0; m_pend = '0; m_h1 = '0; m_h2 = '0; m_h3 = '0;
    for (int i = 0; i < N; i++) m_vec[i] = '0;
    m_a1 = 0; m_a2 = 0; m_a3 = 0;
    m_busy = 0; m_release = 0; m_gid = 0; m_rr = 0;
    m_irq = 0; m_isr = '0; m_rdata = '0;
  endtask

  task automatic m_step();
    logic [N-1:0] rise, clr;
    logic a_rise;
    int w, word;
    rise   = m_h2 & ~m_h3;
    a_rise = m_a2 & ~m_a3;
    clr    = '0;
    m_rdata = m_read(input_addr);
    if (!m_busy && !m_release) begin
      if ((m_pend & m_en) != 0) begin
        w = m_pick(m_pend & m_en);
        m_gid = w; m_isr = m_vec[w]; m_irq = 1; m_busy = 1; m_rr = (w + 1) % N;
      end
    end else if (m_busy) begin
      if (a_rise) begin
        clr[m_gid] = 1'b1; m_irq = 0; m_busy = 0; m_release = 1;
      end
    end else if (!m_a2) begin
      m_release = 0;
    end
    if (write_enable) begin
      word = int'(input_addr >> 2);
      if (word == 0) m_en = write_data[N-1:0];
      else if (word == 1) clr = clr | write_data[N-1:0];
      else if (word >= 4 && word < 4 + N) m_vec[word - 4] = write_data;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = done;
    m_a3 = m_a2; m_a2 = m_a1; m_a1 = IACK;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  always @(negedge clk) begin
    if (rst && chk_on) begin
      chk("model_irq", IRQ, m_irq);
      chk("model_isr_addr", isr_addr, m_isr);
      chk("model_read_data", read_data, m_rdata);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
    write_enable = 1'b1; input_addr = a; write_data = d;
    cyc();
    write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [DW-1:0] a, input logic [DW-1:0] exp);
    input_addr = a;
    cyc();
    chk(name, read_data, exp);
  endtask

  task automatic wait_irq(input string name, input logic v, input int budget);
    int k = 0;
    while (IRQ !== v && k < budget) begin
      cyc();
      k++;
    end
    chk(name, IRQ, v);
  endtask

  task automatic ack(input string name);
    IACK = 1'b1;
    wait_irq(name, 1'b0, 3);
    IACK = 1'b0;
    cyc(4);
  endtask

  function automatic logic [DW-1:0] rand_addr();
    int sel = $urandom_range(0, 11);
    logic [DW-1:0] a;
    if (sel < 8) a = DW'(sel * 4) | DW'($urandom_range(0, 3));
    else if (sel == 8) a = 32'h20;
    else if (sel == 9) a = 32'h24;
    else if (sel == 10) a = $urandom();
    else a = 32'h8000_0004;
    return a;
  endfunction

  logic [DW-1:0] first_exp, second_exp;

  initial begin
`ifdef INTC_ROUND_ROBIN_EN
    first_exp = 32'h400; second_exp = 32'h100;
`else
    first_exp = 32'h100; second_exp = 32'h400;
`endif
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc();
    chk_on = 1'b1;

    rd_chk("rst_enable", 32'h00, 32'h0);
    rd_chk("rst_pending", 32'h04, 32'h0);
    rd_chk("rst_active", 32'h08, 32'h0);
    rd_chk("rst_vector0", 32'h10, 32'h0);
    chk("rst_irq", DW'(IRQ), 32'h0);
    chk("rst_isr_addr", isr_addr, 32'h0);

    wr(32'h18, 32'h300);
    wr(32'h00, 32'h4);
    done[2] = 1'b1;
    wait_irq("t2_irq_within_4", 1'b1, 4);
    done[2] = 1'b0;
    chk("t2_isr_addr", isr_addr, 32'h300);
    rd_chk("t2_active", 32'h08, 32'h8000_0002);
    IACK = 1'b1;
    wait_irq("t2_irq_fall_within_3", 1'b0, 3);
    rd_chk("t2_pending_cleared", 32'h04, 32'h0);
    IACK = 1'b0;
    cyc(3);
    input_addr = 32'h08;
    cyc();
    chk("t2_back_to_idle", DW'(read_data[31]), 32'h0);

    wr(32'h00, 32'h0);
    done[1] = 1'b1; cyc(2); done[1] = 1'b0;
    cyc(3);
    rd_chk("t3_pending_disabled", 32'h04, 32'h2);
    chk("t3_irq_stays_low", DW'(IRQ), 32'h0);
    wr(32'h00, 32'h2);
    wait_irq("t3_irq_after_enable", 1'b1, 2);
    chk("t3_isr_addr", isr_addr, 32'h0);
    ack("t3_ack");

    wr(32'h10, 32'h100);
    wr(32'h1C, 32'h400);
    wr(32'h00, 32'h9);
    done = 4'b1001; cyc(2); done = '0;
    wait_irq("t4_first_irq", 1'b1, 4);
    chk("t4_first_isr", isr_addr, first_exp);
    IACK = 1'b1;
    wait_irq("t4_first_ack", 1'b0, 3);
    IACK = 1'b0;
    wait_irq("t4_second_irq", 1'b1, 8);
    chk("t4_second_isr", isr_addr, second_exp);
    ack("t4_second_ack");

    wr(32'h00, 32'h0);
    done[3] = 1'b1; cyc(2); done[3] = 1'b0;
    cyc(3);
    rd_chk("t5_pending_set", 32'h04, 32'h8);
    wr(32'h04, 32'h8);
    rd_chk("t5_w1c_clears", 32'h04, 32'h0);
    done[3] = 1'b1; cyc(2); done[3] = 1'b0;
    cyc(3);
    rd_chk("t5_pending_set_again", 32'h04, 32'h8);
    done[3] = 1'b1;
    cyc(2);
    write_enable = 1'b1; input_addr = 32'h04; write_data = 32'h8;
    cyc();
    write_enable = 1'b0; done[3] = 1'b0;
    cyc();
    rd_chk("t5_set_beats_clear", 32'h04, 32'h8);

    wr(32'h00, 32'h8);
    input_addr = 32'h1C;
    wait_irq("t6_irq_in_serve", 1'b1, 3);
    chk("t6_isr_before_reset", isr_addr, 32'h400);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_irq", DW'(IRQ), 32'h0);
    chk("t6_async_isr", isr_addr, 32'h0);
    chk("t6_async_rdata", read_data, 32'h0);
    cyc(2);
    rst = 1'b1;
    cyc();
    rd_chk("t6_enable_zero", 32'h00, 32'h0);
    rd_chk("t6_vector3_zero", 32'h1C, 32'h0);
    rd_chk("t6_pending_zero", 32'h04, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) done[b] = ~done[b];
      end
      if ($urandom_range(0, 5) == 0) IACK = ~IACK;
      write_enable = ($urandom_range(0, 3) == 0);
      input_addr   = rand_addr();
      write_data   = $urandom();
      cyc();
    end
    write_enable = 1'b0;
    done = '0;
    IACK = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/intc_core.md
Name: intc_core

Overview:
- Memory-mapped interrupt controller for the host-driven test system.
- Collects up to NUM_SRC "done" event lines and arbitrates among pending, enabled sources.
- Raises a single IRQ to the processor and presents the winning source's ISR vector address.
- Sits behind the host register bridge; it is clocked by the selected system clock (5 KHz divider or host-toggled clock).

Parameters:
- DATA_WIDTH, 32, width of the register bus, write_data, read_data and isr_addr.
- NUM_SRC, 4, number of interrupt sources (legal range 1..8).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- done  in  NUM_SRC  interrupt event lines, asynchronous to clk; a rising edge on bit i is an event for source i.
- IACK  in  1  interrupt acknowledge from the processor, asynchronous to clk, level.
- input_addr  in  DATA_WIDTH  register byte address.
- write_enable  in  1  register write strobe, sampled each clk edge.
- write_data  in  DATA_WIDTH  register write data.
- read_data  out  DATA_WIDTH  registered read data.
- IRQ  out  1  interrupt request, registered.
- isr_addr  out  DATA_WIDTH  vector of the source being serviced, registered.

Behaviour:
- Reset: all registers, ENABLE, PENDING, VECTOR[*], read_data, IRQ and isr_addr go to 0; FSM enters IDLE; synchronizers are cleared.
- Input conditioning: done[i] and IACK each pass through a 2-flop synchronizer. An edge detector on the synchronized value produces a one-cycle rise pulse.
- Register map (byte addresses, word aligned; low 2 bits ignored):
  - 0x00 ENABLE[NUM_SRC-1:0], R/W.
  - 0x04 PENDING, read; writing 1 to a bit clears it (W1C).
  - 0x08 ACTIVE, read-only: bit31 = FSM not IDLE; [2:0] = granted source id.
  - 0x10+4*i VECTOR[i], R/W, full DATA_WIDTH.
  - Unmapped or out-of-range addresses read 0; writes to them are ignored.
- Writes: take effect on the clk edge where write_enable=1.
- Reads: read_data is updated every edge from input_addr, giving 1-cycle latency.
- Pending: a rise pulse on done[i] sets PENDING[i] regardless of ENABLE. If a set and a clear (W1C or IACK clear) hit the same bit in the same cycle, the set wins.
- Arbitration: the lowest index among (PENDING & ENABLE) wins (fixed priority).
- FSM states:
  - IDLE: if (PENDING & ENABLE)!=0, latch the winner id, set isr_addr<=VECTOR[id] and IRQ<=1, then go to SERVE.
  - SERVE: hold IRQ and isr_addr. On the synced IACK rise, clear PENDING[id], set IRQ<=0, go to ACKWAIT. Changes to ENABLE or VECTOR during SERVE do not affect the current grant.
  - ACKWAIT: when synced IACK=0, go to IDLE. isr_addr keeps its last value until the next grant.
- Timing: from done rising (setup met) to PENDING set is 3 edges; to IRQ high is 4 edges. IRQ falls 3 edges after IACK rises.
- An IACK rising while in IDLE is ignored.
- Reset asserted mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro: INTC_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at (last granted id + 1) mod NUM_SRC; after reset it starts at id 0.
- Undefined: fixed lowest-index priority as described above.
- Register map and timing are identical in both cases.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 and 0x10: all return 0; IRQ=0; isr_addr=0.
- Write VECTOR[2]=0x0000_0300 and ENABLE=0x4, pulse done[2]: IRQ=1 and isr_addr=0x300 within 4 edges; ACTIVE=0x8000_0002. Raise IACK: IRQ=0 and PENDING=0. Drop IACK: FSM returns to IDLE.
- Set ENABLE=0x0, pulse done[1]: PENDING reads 0x2 and IRQ stays 0. Then write ENABLE=0x2: IRQ rises.
- Write VECTOR[0]=0x100 and VECTOR[3]=0x400, ENABLE=0x9, pulse done[0] and done[3] together: first isr_addr=0x100; after IACK, second isr_addr=0x400 (with INTC_ROUND_ROBIN_EN, the order depends on the last grant).
- With PENDING=0x8, write 0x04=0x8: PENDING becomes 0. A W1C to bit 3 in the same cycle as a new done[3] edge leaves PENDING=0x8.
- Assert rst low while in SERVE: IRQ=0 and all registers return to 0 asynchronously, before the next clk edge.
